sl_transmitter: RTL and testbench
=================================

Name: sl_transmitter

Overview:
- Transmit end of the two-wire SL serial link. It drives the zeroes and ones lines that the SL receiver samples.
- Takes a parallel word of up to 32 bits from the host. Sends it LSB first, followed by one odd-parity bit and one stop symbol.
- Holds a config register in the same format as the receiver, so the host programs both ends identically.

Parameters:
- LOW_CYCLES, 16, clocks each symbol drives its active-low phase; must be ≥14.
- HIGH_CYCLES, 16, clocks both lines are held high after each symbol; must be ≥8.

Ports:
- clk  input  1  system clock, 16 MHz
- rst  input  1  asynchronous, active-high reset
- tx_data_w  input  32  word to send; bits above BQ are ignored
- tx_start  input  1  request to send tx_data_w
- wr_config_w  input  16  new config value
- wr_enable  input  1  config write strobe
- serial_line_zeroes  output  1  SL zeroes line, registered
- serial_line_ones  output  1  SL ones line, registered
- r_config_w  output  16  current config
- status_w  output  16  status register
- data_status_changed  output  1  one-cycle event pulse

Behaviour:
- Config register: bit 0 PCE (stored only; parity is always sent), bits 6:1 BQ (data bit count), bit 7 MODE, bit 8 IRQM.
  - Reset value 16'h0010 (BQ=8).
  - A write is accepted only in IDLE, and only when the new BQ is even and 8 ≤ BQ ≤ 32. Otherwise the write is ignored silently.
- Status bits:
  - [0] TBF: a word is accepted but not yet started.
  - [1] WTP: word transmission in progress.
  - [3] WTF: last word completed.
  - All other bits read 0. Reset value 16'h0000.
- Symbol encoding (each symbol is a low phase of LOW_CYCLES clocks, then both lines high for HIGH_CYCLES clocks):
  - data 1: ones=0, zeroes=1.
  - data 0: ones=1, zeroes=0.
  - stop: ones=0, zeroes=0.
  - Idle: both lines high. Both lines reset to 1.
- Frame: BQ data bits, LSB first, then a parity bit chosen so that the total count of 1s over data plus parity is odd, then the stop symbol. Frame length is (BQ+2)*(LOW_CYCLES+HIGH_CYCLES) clocks.
- FSM states: IDLE, LOAD, SYM_LOW, SYM_HIGH, STOP_LOW, STOP_HIGH.
  - IDLE: when tx_start=1 → latch tx_data_w, compute parity, set TBF=1 → go to LOAD.
  - LOAD: one clock. TBF=0, WTP=1, WTF=0, pulse data_status_changed, bit_cnt=0 → go to SYM_LOW.
  - SYM_LOW: drive the current symbol for LOW_CYCLES clocks → go to SYM_HIGH.
  - SYM_HIGH: lines high for HIGH_CYCLES clocks, then bit_cnt+1.
    - If bit_cnt now equals BQ+1 → go to STOP_LOW.
    - Otherwise → go to SYM_LOW.
  - STOP_LOW: both lines low for LOW_CYCLES clocks → go to STOP_HIGH.
  - STOP_HIGH: lines high for HIGH_CYCLES clocks. Then WTP=0, WTF=1, pulse data_status_changed → go to IDLE.
- Latency: the first falling edge appears on the lines 2 clocks after tx_start is sampled (one clock for the IDLE latch, one for LOAD).
- tx_start while busy (not IDLE): ignored, unless the double buffer is enabled.
- tx_start and wr_enable in the same IDLE cycle: the config write applies first; the word uses the new BQ.
- Counters: cycle counter is 6 bits; bit counter is 6 bits. Neither wraps, because their bounds are fixed by the parameters and BQ.
- Reset mid-frame: lines go high immediately, state returns to IDLE, status clears, config returns to 16'h0010.
- The receiver detects a symbol on its falling edge after at least 4 high samples. This is guaranteed because HIGH_CYCLES ≥ 8.

Optional Feature:
- Macro SL_TX_DOUBLE_BUFFER_EN.
- Defined:
  - A second holding register accepts tx_start while busy, provided TBF=0. In that case the word is captured and TBF=1.
  - On leaving STOP_HIGH with TBF=1, the FSM goes straight to LOAD, with no IDLE cycle.
  - tx_start while busy with TBF=1 is ignored.
- Undefined: single buffer; tx_start is honoured only in IDLE.

Test Plan:
- Reset, then idle 50 clocks → both lines 1, status_w=0, r_config_w=16'h0010.
- BQ=8, tx_data_w=32'h000000A5, tx_start pulse → symbol sequence 1,0,1,0,0,1,0,1, parity 1, stop. Each low phase is 16 clocks and each high phase 16 clocks. WTF=1 after 320+2 clocks. data_status_changed pulses exactly twice.
- BQ=8, data 32'h000000FF → parity symbol is 1 (8 ones, even, so parity makes it 9). Data 32'h00000007 → parity 0.
- wr_config_w BQ=7, then BQ=34, then BQ=16, each written while idle → only BQ=16 is accepted, so r_config_w=16'h0020. A BQ=10 write during a frame is ignored.
- Loopback into the SL receiver: BQ=16 with data 16'hBEEF, and BQ=32 with data 32'hDEADBEEF → the receiver reports WRF=1 and PEF=WLC=LEF=0, and data_w equals the sent word.
- Assert rst during bit 3 of a frame → lines high within the same cycle, FSM in IDLE. A following tx_start sends a complete, correct frame.

Source files
------------

// File: rtl/sl_transmitter.sv
// ---------------------------------------------------------------------------
// sl_transmitter -- transmit end of the two-wire SL serial link.
//
// Sends a parallel word of BQ bits (8..32, even) LSB first, followed by an
// odd-parity symbol and a stop symbol. Each symbol is an active-low phase of
// LOW_CYCLES clocks followed by HIGH_CYCLES clocks with both lines high.
//   data 1 : zeroes=1, ones=0
//   data 0 : zeroes=0, ones=1
//   stop   : zeroes=0, ones=0
//   idle   : both high
//
// Optional feature macro: SL_TX_DOUBLE_BUFFER_EN
//   When defined, a second word can be queued while a frame is in flight
//   (provided TBF=0); the FSM then chains straight from STOP_HIGH into LOAD.
//
// Ports:
//   clk                 system clock
//   rst                 asynchronous active-high reset
//   tx_data_w[31:0]     word to send (bits at and above BQ ignored)
//   tx_start            send request
//   wr_config_w[15:0]   new config value
//   wr_enable           config write strobe
//   serial_line_zeroes  SL zeroes line (registered)
//   serial_line_ones    SL ones line (registered)
//   r_config_w[15:0]    config: [0] PCE, [6:1] BQ, [7] MODE, [8] IRQM
//   status_w[15:0]      status: [0] TBF, [1] WTP, [3] WTF
//   data_status_changed one-cycle pulse at frame start and frame end
// ---------------------------------------------------------------------------
module sl_transmitter #(
    parameter int LOW_CYCLES  = 16,
    parameter int HIGH_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tx_data_w,
    input  logic        tx_start,
    input  logic [15:0] wr_config_w,
    input  logic        wr_enable,
    output logic        serial_line_zeroes,
    output logic        serial_line_ones,
    output logic [15:0] r_config_w,
    output logic [15:0] status_w,
    output logic        data_status_changed
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SYM_LOW,
        SYM_HIGH,
        STOP_LOW,
        STOP_HIGH
    } state_t;

    localparam logic [5:0] LOW_LAST  = 6'(LOW_CYCLES - 1);
    localparam logic [5:0] HIGH_LAST = 6'(HIGH_CYCLES - 1);

    state_t      r_state;
    logic [5:0]  r_cyc;
    logic [5:0]  r_bit;
    logic [31:0] r_hold;      // accepted word, masked to BQ bits
    logic        r_hold_par;
    logic [31:0] r_shift;     // word being sent, current bit at [0]
    logic        r_par;
    logic [15:0] r_cfg;
    logic        r_tbf;
    logic        r_wtp;
    logic        r_wtf;
    logic        r_dsc;
    logic        r_zeroes;
    logic        r_ones;

    logic [5:0]  w_new_bq;
    logic        w_cfg_ok;
    logic [5:0]  w_bq_eff;
    logic [5:0]  w_bq;
    logic [31:0] w_mask;
    logic [31:0] w_masked;
    logic        w_par;
    logic [5:0]  w_bit_nxt;
    logic        w_cap;

    // Config writes only land while idle and only for an even BQ in 8..32.
    assign w_new_bq = wr_config_w[6:1];
    assign w_cfg_ok = wr_enable && (r_state == IDLE) && !w_new_bq[0]
                      && (w_new_bq >= 6'd8) && (w_new_bq <= 6'd32);

    // A word started in the same cycle as a config write uses the new BQ.
    assign w_bq_eff = w_cfg_ok ? w_new_bq : r_cfg[6:1];
    assign w_bq     = r_cfg[6:1];

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 32; i++) begin
            w_mask[i] = (6'(i) < w_bq_eff);
        end
    end

    assign w_masked  = tx_data_w & w_mask;
    // Odd parity: set when the data holds an even number of ones.
    assign w_par     = ~(^w_masked);
    assign w_bit_nxt = r_bit + 6'd1;

`ifdef SL_TX_DOUBLE_BUFFER_EN
    // Queue a second word while a frame is running and the holding slot is free.
    assign w_cap = tx_start && !r_tbf && (r_state != IDLE) && (r_state != LOAD);
`else
    assign w_cap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cyc      <= '0;
            r_bit      <= '0;
            r_hold     <= '0;
            r_hold_par <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_cfg      <= 16'h0010;
            r_tbf      <= 1'b0;
            r_wtp      <= 1'b0;
            r_wtf      <= 1'b0;
            r_dsc      <= 1'b0;
            r_zeroes   <= 1'b1;
            r_ones     <= 1'b1;
        end else begin
            r_dsc <= 1'b0;
            if (w_cfg_ok) begin
                r_cfg <= wr_config_w;
            end
            if (w_cap) begin
                r_hold     <= w_masked;
                r_hold_par <= w_par;
                r_tbf      <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_zeroes <= 1'b1;
                    r_ones   <= 1'b1;
                    if (tx_start) begin
                        r_hold     <= w_masked;
                        r_hold_par <= w_par;
                        r_tbf      <= 1'b1;
                        r_state    <= LOAD;
                    end
                end

                LOAD: begin
                    r_tbf    <= 1'b0;
                    r_wtp    <= 1'b1;
                    r_wtf    <= 1'b0;
                    r_dsc    <= 1'b1;
                    r_bit    <= '0;
                    r_cyc    <= '0;
                    r_shift  <= r_hold;
                    r_par    <= r_hold_par;
                    // BQ >= 8, so the first symbol is always a data bit.
                    r_zeroes <= r_hold[0];
                    r_ones   <= ~r_hold[0];
                    r_state  <= SYM_LOW;
                end

                SYM_LOW: begin
                    if (r_cyc == LOW_LAST) begin
                        r_cyc    <= '0;
                        r_zeroes <= 1'b1;
                        r_ones   <= 1'b1;
                        r_state  <= SYM_HIGH;
                    end else begin
                        r_cyc <= r_cyc + 6'd1;
                    end
                end

                SYM_HIGH: begin
                    if (r_cyc == HIGH_LAST) begin
                        r_cyc   <= '0;
                        r_bit   <= w_bit_nxt;
                        r_shift <= r_shift >> 1;
                        if (w_bit_nxt == w_bq + 6'd1) begin
                            r_zeroes <= 1'b0;
                            r_ones   <= 1'b0;
                            r_state  <= STOP_LOW;
                        end else if (w_bit_nxt == w_bq) begin
                            r_zeroes <= r_par;
                            r_ones   <= ~r_par;
                            r_state  <= SYM_LOW;
                        end else begin
                            // r_shift[1] becomes the current bit after this shift.
                            r_zeroes <= r_shift[1];
                            r_ones   <= ~r_shift[1];
                            r_state  <= SYM_LOW;
                        end
                    end else begin
                        r_cyc <= r_cyc + 6'd1;
                    end
                end

                STOP_LOW: begin
                    if (r_cyc == LOW_LAST) begin
                        r_cyc    <= '0;
                        r_zeroes <= 1'b1;
                        r_ones   <= 1'b1;
                        r_state  <= STOP_HIGH;
                    end else begin
                        r_cyc <= r_cyc + 6'd1;
                    end
                end

                STOP_HIGH: begin
                    if (r_cyc == HIGH_LAST) begin
                        r_cyc <= '0;
                        r_wtp <= 1'b0;
                        r_wtf <= 1'b1;
                        r_dsc <= 1'b1;
                        // A queued word (including one captured this very
                        // cycle) chains directly into LOAD.
                        if (r_tbf || w_cap) begin
                            r_state <= LOAD;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cyc <= r_cyc + 6'd1;
                    end
                end

                default: begin
                    r_zeroes <= 1'b1;
                    r_ones   <= 1'b1;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign serial_line_zeroes  = r_zeroes;
    assign serial_line_ones    = r_ones;
    assign r_config_w          = r_cfg;
    assign status_w            = {12'h000, r_wtf, 1'b0, r_wtp, r_tbf};
    assign data_status_changed = r_dsc;

endmodule

// File: tb/tb_sl_transmitter.sv
// ---------------------------------------------------------------------------
// tb_sl_transmitter -- self-checking bench for sl_transmitter.
// A reference model builds the expected symbol train of each frame from the
// word, BQ and the odd-parity rule, and the observed lines are also decoded
// back into a word as a receiver would.
// ---------------------------------------------------------------------------
module tb_sl_transmitter;

    localparam int LOWC  = 16;
    localparam int HIGHC = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tx_data_w = '0;
    logic        tx_start = 1'b0;
    logic [15:0] wr_config_w = '0;
    logic        wr_enable = 1'b0;
    logic        serial_line_zeroes;
    logic        serial_line_ones;
    logic [15:0] r_config_w;
    logic [15:0] status_w;
    logic        data_status_changed;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [15:0] model_cfg = 16'h0010;
    logic        model_wtf = 1'b0;

    sl_transmitter #(.LOW_CYCLES(LOWC), .HIGH_CYCLES(HIGHC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .tx_data_w           (tx_data_w),
        .tx_start            (tx_start),
        .wr_config_w         (wr_config_w),
        .wr_enable           (wr_enable),
        .serial_line_zeroes  (serial_line_zeroes),
        .serial_line_ones    (serial_line_ones),
        .r_config_w          (r_config_w),
        .status_w            (status_w),
        .data_status_changed (data_status_changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit cfg_ok(input logic [15:0] v);
        int b;
        b = int'(v[6:1]);
        return (b % 2 == 0) && (b >= 8) && (b <= 32);
    endfunction

    // {zeroes, ones} during the low phase of a data/parity symbol
    function automatic logic [1:0] code_of(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    task automatic wr_cfg(input logic [15:0] v);
        wr_config_w = v;
        wr_enable   = 1'b1;
        @(negedge clk);
        wr_enable = 1'b0;
        if (cfg_ok(v)) model_cfg = v;
        chk($sformatf("cfg_wr_%h", v), r_config_w, model_cfg);
    endtask

    // Starts a frame from idle (called at a negedge) and checks it end to end.
    task automatic send_frame(input logic [31:0] data, input bit with_cfg,
                              input logic [15:0] cfg_val, input bit mid_cfg);
        int          bq;
        int          nsym;
        int          dsc_cnt;
        int          ones;
        logic [31:0] mask;
        logic [31:0] rx;
        logic [63:0] obs;
        logic [1:0]  exp_code;
        logic [1:0]  c;

        if (with_cfg && cfg_ok(cfg_val)) model_cfg = cfg_val;
        bq   = int'(model_cfg[6:1]);
        nsym = bq + 2;
        mask = '0;
        for (int i = 0; i < bq; i++) mask[i] = 1'b1;

        tx_data_w   = data;
        tx_start    = 1'b1;
        wr_enable   = with_cfg;
        wr_config_w = cfg_val;
        @(posedge clk);
        @(negedge clk);
        tx_start  = 1'b0;
        wr_enable = 1'b0;
        tx_data_w = $urandom;   // the latched word must not follow the bus
        chk("cfg_at_start", r_config_w, model_cfg);
        chk("status_load", status_w, {12'h000, model_wtf, 3'b001});

        dsc_cnt = 0;
        rx      = '0;
        ones    = 0;
        @(negedge clk);
        chk("status_running", status_w, 16'h0002);

        for (int s = 0; s < nsym; s++) begin
            obs = '0;
            for (int cy = 0; cy < LOWC + HIGHC; cy++) begin
                obs = {obs[61:0], serial_line_zeroes, serial_line_ones};
                dsc_cnt += int'(data_status_changed);
                if (mid_cfg && s == 1 && cy == 0) begin
                    wr_config_w = 16'h0014;
                    wr_enable   = 1'b1;
                end else begin
                    wr_enable = 1'b0;
                end
                @(negedge clk);
            end
            if (s < bq)       exp_code = code_of(data[s]);
            else if (s == bq) exp_code = code_of(~(^(data & mask)));
            else              exp_code = 2'b00;
            chk($sformatf("sym%0d_bq%0d", s, bq), obs, {{16{exp_code}}, {16{2'b11}}});

            // receiver-side decode of the low phase
            c = obs[63:62];
            if (s <= bq && c == 2'b10) ones++;
            if (s < bq) rx[s] = (c == 2'b10);
        end

        dsc_cnt += int'(data_status_changed);
        chk("status_done", status_w, 16'h0008);
        chk("dsc_pulses", dsc_cnt, 2);
        chk("lines_idle_after", {serial_line_zeroes, serial_line_ones}, 2'b11);
        chk("cfg_after", r_config_w, model_cfg);
        chk("rx_word", rx, data & mask);
        chk("rx_parity_odd", ones % 2, 1);
        model_wtf = 1'b1;
    endtask

    initial begin
        int          hi_cnt;
        logic [31:0] d;
        logic [15:0] cv;
        logic [5:0]  bqf;

        // reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hi_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (serial_line_zeroes === 1'b1 && serial_line_ones === 1'b1 &&
                data_status_changed === 1'b0) hi_cnt++;
        end
        chk("idle_lines_high", hi_cnt, 50);
        chk("reset_status", status_w, 16'h0000);
        chk("reset_config", r_config_w, 16'h0010);

        // directed BQ=8 frames
        send_frame(32'h000000A5, 1'b0, 16'h0000, 1'b0);
        send_frame(32'h000000FF, 1'b0, 16'h0000, 1'b0);
        send_frame(32'h00000007, 1'b0, 16'h0000, 1'b0);

        // config write acceptance
        wr_cfg(16'h000E);   // BQ=7
        wr_cfg(16'h0044);   // BQ=34
        wr_cfg(16'h0020);   // BQ=16
        chk("cfg_bq16", r_config_w, 16'h0020);

        // a config write in mid-frame must be dropped
        send_frame($urandom, 1'b0, 16'h0000, 1'b1);

        // loopback words
        send_frame(32'h0000BEEF, 1'b0, 16'h0000, 1'b0);
        wr_cfg(16'h0040);   // BQ=32
        send_frame(32'hDEADBEEF, 1'b0, 16'h0000, 1'b0);

        // random frames with a simultaneous config write (valid or not)
        for (int n = 0; n < 6; n++) begin
            if ($urandom_range(0, 2) != 0) bqf = 6'(8 + 2 * $urandom_range(0, 12));
            else                           bqf = 6'($urandom_range(0, 63));
            cv = 16'($urandom);
            cv[6:1] = bqf;
            d = $urandom;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_frame(d, 1'b1, cv, 1'b0);
        end

        // reset during bit 3 of a BQ=16 frame
        wr_cfg(16'h0020);
        d = $urandom;
        tx_data_w = d;
        tx_start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_start = 1'b0;
        repeat (1 + 3 * (LOWC + HIGHC) + 8) @(negedge clk);
        chk("bit3_low_before_rst", {serial_line_zeroes, serial_line_ones}, code_of(d[3]));
        #2 rst = 1'b1;
        #1;
        chk("rst_lines_high", {serial_line_zeroes, serial_line_ones}, 2'b11);
        chk("rst_status", status_w, 16'h0000);
        chk("rst_config", r_config_w, 16'h0010);
        @(negedge clk);
        rst = 1'b0;
        model_cfg = 16'h0010;
        model_wtf = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", {serial_line_zeroes, serial_line_ones, status_w}, {2'b11, 16'h0000});
        send_frame($urandom, 1'b0, 16'h0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
